// File: rtl/cpu_wishbone_master_if.sv
// Wishbone classic bus bundle between the CPU bridge and a slave.
// master drives addr/data/we/sel/stb/cyc; slave returns data and ack.
interface cpu_wishbone_master_if;
  logic [31:0] wishbone_addr_o;
  logic [31:0] wishbone_data_o;
  logic        wishbone_we_o;
  logic [3:0]  wishbone_sel_o;
  logic        wishbone_stb_o;
  logic        wishbone_cyc_o;
  logic [31:0] wishbone_data_i;
  logic        wishbone_ack_i;

  modport master (
    output wishbone_addr_o,
    output wishbone_data_o,
    output wishbone_we_o,
    output wishbone_sel_o,
    output wishbone_stb_o,
    output wishbone_cyc_o,
    input  wishbone_data_i,
    input  wishbone_ack_i
  );

  modport slave (
    input  wishbone_addr_o,
    input  wishbone_data_o,
    input  wishbone_we_o,
    input  wishbone_sel_o,
    input  wishbone_stb_o,
    input  wishbone_cyc_o,
    output wishbone_data_i,
    output wishbone_ack_i
  );
endinterface

// File: rtl/cpu_wishbone_master.sv
// CPU memory port to Wishbone classic master; one bus cycle per request.
// Ports: clk, rst_n, cpu_* request, stall/flush, err_o, wb master modport.
// Optional WB_TIMEOUT_EN: abort a BUSY cycle after TIMEOUT_CYCLES, pulse err_o.
module cpu_wishbone_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        stall_req_o,
  output logic        err_o,
  cpu_wishbone_master_if.master wb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] rd_buf, rd_buf_n;
  logic        start;
  logic        drop;

`ifdef WB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TMO_LAST =
    TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (state == BUSY && !wb.wishbone_ack_i) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    rd_buf_n    = rd_buf;
    stall_req_o = 1'b0;
    cpu_data_o  = '0;
    err_o       = 1'b0;
    start       = 1'b0;
    drop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          stall_req_o = 1'b1;
          start       = 1'b1;
          state_n     = BUSY;
        end
      end
      BUSY: begin
        if (flush_i) begin
          drop    = 1'b1;
          state_n = IDLE;
        end else if (wb.wishbone_ack_i) begin
          cpu_data_o = wb.wishbone_we_o ? 32'h0
                                        : wb.wishbone_data_i;
          rd_buf_n   = cpu_data_o;
          drop       = 1'b1;
          state_n    = stall_i ? HOLD : IDLE;
`ifdef WB_TIMEOUT_EN
        end else if (cnt == TMO_LAST) begin
          err_o   = 1'b1;
          drop    = 1'b1;
          state_n = IDLE;
`endif
        end else begin
          stall_req_o = 1'b1;
        end
      end
      HOLD: begin
        cpu_data_o = rd_buf;
        if (!stall_i || flush_i) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // keep the pipeline free while reset is asserted
    if (!rst_n) begin
      stall_req_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.wishbone_addr_o <= '0;
      wb.wishbone_data_o <= '0;
      wb.wishbone_we_o   <= 1'b0;
      wb.wishbone_sel_o  <= '0;
      wb.wishbone_stb_o  <= 1'b0;
      wb.wishbone_cyc_o  <= 1'b0;
      rd_buf             <= '0;
    end else begin
      rd_buf <= rd_buf_n;
      if (start) begin
        wb.wishbone_addr_o <= cpu_addr_i;
        wb.wishbone_data_o <= cpu_data_i;
        wb.wishbone_we_o   <= cpu_we_i;
        wb.wishbone_sel_o  <= cpu_sel_i;
        wb.wishbone_stb_o  <= 1'b1;
        wb.wishbone_cyc_o  <= 1'b1;
      end else if (drop) begin
        wb.wishbone_we_o   <= 1'b0;
        wb.wishbone_sel_o  <= '0;
        wb.wishbone_stb_o  <= 1'b0;
        wb.wishbone_cyc_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_wishbone_master.sv
// Self-checking bench for cpu_wishbone_master with a small RAM slave.
// Directed vector table plus flush, back-to-back, timeout and reset cases.
module tb_cpu_wishbone_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_ce;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall_i;
  logic        flush;
  logic        stall_req;
  logic        err;
  logic        ext_stall;
  logic        ack_en;
  logic        force_ack;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_wishbone_master_if wb ();

  always #5 clk = ~clk;

  assign stall_i = stall_req | ext_stall;

  cpu_wishbone_master #(
    .TIMEOUT_CYCLES(4),
    .TIMEOUT_W     (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_ce_i   (cpu_ce),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_sel_i  (cpu_sel),
    .cpu_data_i (cpu_wdata),
    .cpu_data_o (cpu_rdata),
    .stall_i    (stall_i),
    .flush_i    (flush),
    .stall_req_o(stall_req),
    .err_o      (err),
    .wb         (wb.master)
  );

  // RAM slave: 16 words, registered 1-cycle ack
  logic [31:0] mem [16];
  logic [31:0] s_rdata;
  logic        ack_q;
  logic        s_hit;

  assign s_hit = ack_en && wb.wishbone_stb_o
              && wb.wishbone_cyc_o && !ack_q;
  assign wb.wishbone_data_i = s_rdata;
  assign wb.wishbone_ack_i  = ack_q | force_ack;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      s_rdata <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h5555_5555;
      mem[4] <= 32'hCAFE_BABE;
      mem[8] <= 32'h1122_3344;
    end else begin
      ack_q <= s_hit;
      if (s_hit) begin
        if (wb.wishbone_we_o) begin
          for (int b = 0; b < 4; b++)
            if (wb.wishbone_sel_o[b])
              mem[wb.wishbone_addr_o[5:2]][8*b +: 8]
                <= wb.wishbone_data_o[8*b +: 8];
        end else begin
          s_rdata <= mem[wb.wishbone_addr_o[5:2]];
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [7];

  // wait (bounded) for the ack cycle; returns cycles after request
  task automatic wait_ack(output int n);
    n = 0;
    while (stall_req && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    @(negedge clk);
    cpu_ce    = 1'b1;
    cpu_we    = v.we;
    cpu_addr  = v.addr;
    cpu_sel   = v.sel;
    cpu_wdata = v.wdata;
    ext_stall = (v.hold != 0);
    #1;
    chk("req_stall", stall_req, 1);
    @(negedge clk);
    chk("busy_stb", wb.wishbone_stb_o, 1);
    chk("busy_cyc", wb.wishbone_cyc_o, 1);
    chk("busy_addr", wb.wishbone_addr_o, v.addr);
    chk("busy_we", wb.wishbone_we_o, v.we);
    chk("busy_sel", wb.wishbone_sel_o, v.sel);
    if (v.we) chk("busy_wdata", wb.wishbone_data_o, v.wdata);
    wait_ack(n);
    chk("ack_latency", n, 1);
    chk("ack_rdata", cpu_rdata, v.exp);
    chk("ack_err", err, 0);
    cpu_ce = 1'b0;
    if (v.hold != 0) begin
      for (int k = 0; k < v.hold; k++) begin
        @(negedge clk);
        chk("hold_rdata", cpu_rdata, v.exp);
        chk("hold_stall", stall_req, 0);
        chk("hold_stb", wb.wishbone_stb_o, 0);
      end
      ext_stall = 1'b0;
    end
    @(negedge clk);
    chk("gap_stb", wb.wishbone_stb_o, 0);
    chk("gap_cyc", wb.wishbone_cyc_o, 0);
    chk("idle_rdata", cpu_rdata, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vt[0] = '{1'b0, 32'h10, 4'hF, 32'h0,         0, 32'hCAFE_BABE};
    vt[1] = '{1'b1, 32'h20, 4'h2, 32'h0000_AB00, 0, 32'h0};
    vt[2] = '{1'b0, 32'h20, 4'hF, 32'h0,         0, 32'h1122_AB44};
    vt[3] = '{1'b1, 32'h24, 4'hF, 32'hDEAD_BEEF, 0, 32'h0};
    vt[4] = '{1'b0, 32'h24, 4'h0, 32'h0,         0, 32'hDEAD_BEEF};
    vt[5] = '{1'b1, 32'h28, 4'h9, 32'hAA00_00BB, 0, 32'h0};
    vt[6] = '{1'b0, 32'h28, 4'hF, 32'h0,         3, 32'hAA55_55BB};

    rst_n = 1'b0;
    cpu_ce = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 32'h10;
    cpu_sel = 4'hF;
    cpu_wdata = '0;
    flush = 1'b0;
    ext_stall = 1'b0;
    ack_en = 1'b1;
    force_ack = 1'b0;
    #12;
    chk("rst_stb", wb.wishbone_stb_o, 0);
    chk("rst_cyc", wb.wishbone_cyc_o, 0);
    chk("rst_addr", wb.wishbone_addr_o, 0);
    chk("rst_sel", wb.wishbone_sel_o, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    cpu_ce = 1'b0;
    rst_n = 1'b1;

    foreach (vt[i]) run_vec(vt[i]);

    // back-to-back with the request held across the ack
    @(negedge clk);
    cpu_ce = 1'b1; cpu_we = 1'b0;
    cpu_addr = 32'h10; cpu_sel = 4'hF;
    #1;
    wait_ack(n);
    chk("b2b_first", cpu_rdata, 32'hCAFE_BABE);
    cpu_addr = 32'h20;
    @(negedge clk);
    chk("b2b_gap_stb", wb.wishbone_stb_o, 0);
    chk("b2b_gap_stall", stall_req, 1);
    @(negedge clk);
    chk("b2b_addr", wb.wishbone_addr_o, 32'h20);
    wait_ack(n);
    chk("b2b_second", cpu_rdata, 32'h1122_AB44);
    cpu_ce = 1'b0;

    // flush in the first BUSY cycle, then a stray ack
    @(negedge clk);
    ack_en = 1'b0;
    cpu_ce = 1'b1; cpu_addr = 32'h10;
    @(negedge clk);
    chk("fl_busy_stb", wb.wishbone_stb_o, 1);
    flush = 1'b1;
    #1;
    chk("fl_stall", stall_req, 0);
    chk("fl_rdata", cpu_rdata, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    cpu_ce = 1'b0;
    @(negedge clk);
    chk("fl_stb", wb.wishbone_stb_o, 0);
    chk("fl_cyc", wb.wishbone_cyc_o, 0);
    force_ack = 1'b1;
    #1;
    chk("late_ack_rdata", cpu_rdata, 0);
    chk("late_ack_stall", stall_req, 0);
    @(negedge clk);
    force_ack = 1'b0;
    chk("late_ack_stb", wb.wishbone_stb_o, 0);

`ifdef WB_TIMEOUT_EN
    // slave never acks: abort in the 4th BUSY cycle
    @(negedge clk);
    cpu_ce = 1'b1; cpu_addr = 32'h10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("tmo_wait_err", err, 0);
      chk("tmo_wait_stb", wb.wishbone_stb_o, 1);
      chk("tmo_wait_stall", stall_req, 1);
    end
    @(negedge clk);
    chk("tmo_err", err, 1);
    chk("tmo_stall", stall_req, 0);
    chk("tmo_rdata", cpu_rdata, 0);
    cpu_ce = 1'b0;
    @(negedge clk);
    chk("tmo_err_off", err, 0);
    chk("tmo_stb", wb.wishbone_stb_o, 0);
    chk("tmo_cyc", wb.wishbone_cyc_o, 0);
`else
    // no timeout: BUSY holds while the slave stays silent
    @(negedge clk);
    cpu_ce = 1'b1; cpu_addr = 32'h10;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("wait_stb", wb.wishbone_stb_o, 1);
      chk("wait_stall", stall_req, 1);
      chk("wait_err", err, 0);
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    cpu_ce = 1'b0;
    @(negedge clk);
    chk("wait_fl_stb", wb.wishbone_stb_o, 0);
`endif

    // asynchronous reset while BUSY
    @(negedge clk);
    cpu_ce = 1'b1; cpu_addr = 32'h24; cpu_sel = 4'hF;
    @(negedge clk);
    chk("ar_busy_stb", wb.wishbone_stb_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_stb", wb.wishbone_stb_o, 0);
    chk("ar_cyc", wb.wishbone_cyc_o, 0);
    chk("ar_addr", wb.wishbone_addr_o, 0);
    chk("ar_sel", wb.wishbone_sel_o, 0);
    chk("ar_stall", stall_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    cpu_addr = 32'h10;
    #1;
    chk("ar_idle_stall", stall_req, 1);
    chk("ar_idle_stb", wb.wishbone_stb_o, 0);
    wait_ack(n);
    chk("ar_lat", n, 2);
    chk("ar_rdata", cpu_rdata, 32'hCAFE_BABE);
    cpu_ce = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_wishbone_master.md
Name: cpu_wishbone_master

Overview:
- Bus-master bridge between one CPU pipeline memory port (instruction fetch or MEM stage) and a Wishbone classic bus.
- Directly upstream of the data RAM slave.
- Converts a level-held CPU request into exactly one Wishbone cycle and stalls the pipeline until ack.
- Returns read data and holds it while the pipeline is still frozen by other stall sources.
- Supports pipeline flush at any point.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in BUSY without ack before abort (used only with WB_TIMEOUT_EN).
- TIMEOUT_W, 8: width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- Interface rule: reset rst_n, asynchronous, active-low; clock clk.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_ce_i  in  1  CPU access request, held until stall_req_o falls.
- cpu_we_i  in  1  1=write, 0=read.
- cpu_addr_i  in  32  byte address.
- cpu_sel_i  in  4  byte lanes.
- cpu_data_i  in  32  write data.
- cpu_data_o  out  32  read data to pipeline.
- stall_i  in  1  global pipeline stall from the controller (includes own stall_req_o).
- flush_i  in  1  pipeline flush; kills the pending or in-flight access.
- stall_req_o  out  1  stall request to the pipeline controller.
- wishbone_addr_o  out  32  bus address.
- wishbone_data_o  out  32  bus write data.
- wishbone_we_o  out  1  bus write enable.
- wishbone_sel_o  out  4  bus byte select.
- wishbone_stb_o  out  1  bus strobe.
- wishbone_cyc_o  out  1  bus cycle.
- wishbone_data_i  in  32  bus read data.
- wishbone_ack_i  in  1  bus acknowledge.
- err_o  out  1  one-cycle timeout error pulse; constant 0 without WB_TIMEOUT_EN.

Behaviour:
- Reset: state=IDLE. All wishbone_*_o = 0, cpu_data_o = 0, rd_buf = 0, stall_req_o = 0, err_o = 0, timeout counter = 0.
- Wishbone outputs are registered. stall_req_o and cpu_data_o are combinational from state, ack and rd_buf.
- State IDLE: stb = cyc = 0.
  - If cpu_ce_i=1 and flush_i=0: register addr/data/we/sel from CPU, set stb = cyc = 1, go to BUSY.
  - stall_req_o = cpu_ce_i & ~flush_i. cpu_data_o = 0.
- State BUSY: stb, cyc and the bus fields are held stable.
  - If flush_i=1 (takes priority over ack): clear stb/cyc/we/sel, go to IDLE, stall_req_o = 0. A write already sampled by the slave is not undone.
  - Else if wishbone_ack_i=1: stall_req_o = 0 in this same cycle. cpu_data_o = wishbone_data_i for reads, 0 for writes. Latch the same value into rd_buf. Clear stb/cyc/we/sel at the edge. Go to HOLD if stall_i=1, else IDLE.
  - Else: stall_req_o = 1, cpu_data_o = 0.
- State HOLD: stall_req_o = 0, cpu_data_o = rd_buf, bus idle.
  - Go to IDLE when stall_i=0 or flush_i=1.
- Timing:
  - Minimum read latency: request cycle N, stb high N+1, with a 1-cycle slave ack at N+2 the data is valid at N+2.
  - Back-to-back accesses always have at least one cycle with stb/cyc low between them, so the slave sees a fresh request rising edge.
- An ack received in IDLE or HOLD is ignored.
- Reset mid-cycle drops stb/cyc immediately (asynchronous).
- sel=0 read: the bus cycle is still issued and the returned data passes through unchanged.

Optional Feature:
- Macro WB_TIMEOUT_EN.
- Enabled: the counter clears on entry to BUSY and increments each BUSY cycle without ack. When it reaches TIMEOUT_CYCLES:
  - treat as an abort: clear stb/cyc, go to IDLE;
  - stall_req_o = 0 and cpu_data_o = 0 in that cycle;
  - err_o = 1 for exactly that cycle.
- Disabled: no counter; BUSY waits indefinitely; err_o tied to 0.

Test Plan:
- Read with 1-cycle ack slave, RAM word 0x10 = 0xCAFEBABE, cpu_ce_i=1 we=0 addr=0x10 sel=0xF, stall_i=0 → stb high 1 cycle before ack; cpu_data_o=0xCAFEBABE and stall_req_o=0 in the ack cycle; stb low the next cycle.
- Byte write: addr=0x20 sel=0x2 data=0x0000AB00, then read 0x20 sel=0xF → bits 15:8 = 0xAB, other bytes unchanged; stb/cyc low ≥1 cycle between the two accesses.
- Ack while stall_i=1 held 3 further cycles → HOLD; cpu_data_o stays equal to the acked data for those 3 cycles; returns to IDLE when stall_i falls.
- Flush in the first BUSY cycle (before ack) → stb/cyc = 0 next cycle, stall_req_o = 0, no data returned; a late ack is ignored.
- WB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks → after 4 BUSY cycles err_o pulses 1 cycle, stb/cyc drop, cpu_data_o=0.
- Assert rst_n low during BUSY → all wishbone outputs and stall_req_o go to 0 asynchronously; state is IDLE after release.
